ffs_arb: RTL

- Round-robin scheduler that shares one modular add/sub unit (field GF(P), P = 2^255-19) between N requesters in the point-arithmetic datapath.
- Arbitrates between pending requests, latches the winner's operands, and issues a single-cycle start pulse to the unit. It then waits for the unit's valid, returns the result to the winner, and guards against a hung unit with a watchdog.
- Sits between the scalar-multiplication sequencer lanes and the shared field add/sub unit.

---
 rtl/ffs_arb.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/ffs_arb.sv
// Round-robin scheduler sharing one GF(2^255-19) add/sub unit between N requesters.
// Grants, issues a one-cycle start, waits for the unit (with watchdog) and returns the result.
module ffs_arb #(
  parameter int N       = 4,
  parameter int W       = 255,
  parameter int TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   req_op,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  output logic [N-1:0]   done,
  output logic [W-1:0]   rsp_result,
  output logic           rsp_err,
  output logic           busy,
  output logic           fu_start,
  output logic           fu_op,
  output logic [W-1:0]   fu_a,
  output logic [W-1:0]   fu_b,
  input  logic [W-1:0]   fu_result,
  input  logic           fu_valid
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] win_q, win_d;
  logic [TW-1:0] wd_q, wd_d;
  logic          op_q, op_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  res_q, res_d;
  logic          err_q, err_d;
  logic          start_q, start_d;
  logic          busy_q, busy_d;
  logic [N-1:0]  done_q, done_d;

  logic          found;
  logic [PW-1:0] sel;
  logic [PW-1:0] cand;

  // First pending request at or above the pointer, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = ptr_q;
    cand  = ptr_q;
    for (int k = 0; k < N; k++) begin
      cand = PW'((int'(ptr_q) + k) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    wd_d    = wd_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    err_d   = err_q;
    start_d = 1'b0;
    done_d  = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          win_d   = sel;
          op_d    = req_op[sel];
          a_d     = req_a[sel*W +: W];
          b_d     = req_b[sel*W +: W];
          start_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (fu_valid) begin
          res_d         = fu_result;
          err_d         = 1'b0;
          done_d[win_q] = 1'b1;
          state_d       = RESP;
        end else if (wd_q == TW'(TIMEOUT - 1)) begin
          res_d         = '0;
          err_d         = 1'b1;
          done_d[win_q] = 1'b1;
          state_d       = RESP;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      RESP: begin
        ptr_d   = (win_q == PW'(N - 1)) ? '0 : win_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      wd_q    <= '0;
      op_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      wd_q    <= wd_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      err_q   <= err_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign done       = done_q;
  assign rsp_result = res_q;
  assign rsp_err    = err_q;
  assign busy       = busy_q;
  assign fu_start   = start_q;
  assign fu_op      = op_q;
  assign fu_a       = a_q;
  assign fu_b       = b_q;

endmodule
